// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit; optional MULDIV_FAST_MUL_EN gives single-cycle multiplies.
// Latency: 32 edges from capture to RESULT_VALID when iterating, 1 edge for fast paths.
// Backpressure: START is ignored while BUSY or while a fast-path result is pending; nothing is queued.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [2:0]       FUNCT3,
  input  logic [WIDTH-1:0] OPERAND1,
  input  logic [WIDTH-1:0] OPERAND2,
  input  logic [4:0]       DEST_ADDRESS,
  input  logic             FLUSH,
  output logic             BUSY,
  output logic             RESULT_VALID,
  output logic [WIDTH-1:0] RESULT,
  output logic [4:0]       RESULT_ADDRESS
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state, state_nxt;
  logic [2:0]         op_q;
  logic [4:0]         dest_q, cnt;
  logic               neg_q, fast_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc;

  logic               is_mul, sgn1, sgn2, neg_in, div_zero, div_ovf, fast_hit, accept;
  logic [WIDTH-1:0]   mag1, mag2, fast_val;

  always_comb begin
    is_mul   = !FUNCT3[2];
    sgn1     = OPERAND1[WIDTH-1] & (is_mul ? (FUNCT3[1:0] == 2'd1 || FUNCT3[1:0] == 2'd2) : !FUNCT3[0]);
    sgn2     = OPERAND2[WIDTH-1] & (is_mul ? (FUNCT3[1:0] == 2'd1) : !FUNCT3[0]);
    mag1     = sgn1 ? -OPERAND1 : OPERAND1;
    mag2     = sgn2 ? -OPERAND2 : OPERAND2;
    // Remainder takes the dividend's sign; products and quotients take the XOR.
    neg_in   = (!is_mul && FUNCT3[1]) ? sgn1 : (sgn1 ^ sgn2);
    div_zero = !is_mul && (OPERAND2 == '0);
    div_ovf  = !is_mul && !FUNCT3[0] && (OPERAND1 == MIN_INT) && (OPERAND2 == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*WIDTH-1:0] fm_a, fm_b, fm_p;
  always_comb begin
    fm_a = {{WIDTH{sgn1}}, OPERAND1};
    fm_b = {{WIDTH{sgn2}}, OPERAND2};
    fm_p = fm_a * fm_b;
  end
`endif

  always_comb begin
    fast_hit = div_zero | div_ovf;
    fast_val = '0;
    if (div_zero)
      fast_val = FUNCT3[1] ? OPERAND1 : '1;
    else if (div_ovf)
      fast_val = FUNCT3[1] ? '0 : MIN_INT;
`ifdef MULDIV_FAST_MUL_EN
    if (is_mul) begin
      fast_hit = 1'b1;
      fast_val = (FUNCT3[1:0] == 2'd0) ? fm_p[WIDTH-1:0] : fm_p[2*WIDTH-1:WIDTH];
    end
`endif
  end

  assign accept = (state != CALC) && !fast_q && START && !FLUSH;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_nxt, prod_fix;
  logic [WIDTH:0]     mul_sum, shifted;
  logic [WIDTH-1:0]   div_sub, div_sel, final_res;
  logic               no_borrow;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
    shifted   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    no_borrow = shifted >= {1'b0, opnd_q};
    div_sub   = shifted[WIDTH-1:0] - opnd_q;
    if (op_q[2])
      acc_nxt = no_borrow ? {div_sub, acc[WIDTH-2:0], 1'b1}
                          : {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    prod_fix = neg_q ? -acc_nxt : acc_nxt;
    div_sel  = op_q[1] ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
    if (!op_q[2])
      final_res = (op_q[1:0] == 2'd0) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    else
      final_res = neg_q ? -div_sel : div_sel;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    BUSY         = (state == CALC);
    RESULT_VALID = (state == DONE);
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (!FLUSH) begin
          if (fast_q)                  state_nxt = DONE;
          else if (START && !fast_hit) state_nxt = CALC;
        end
      end
      CALC: begin
        if (FLUSH)              state_nxt = IDLE;
        else if (cnt == 5'd0)   state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      op_q           <= '0;
      dest_q         <= '0;
      cnt            <= '0;
      neg_q          <= 1'b0;
      fast_q         <= 1'b0;
      opnd_q         <= '0;
      acc            <= '0;
      RESULT         <= '0;
      RESULT_ADDRESS <= '0;
    end else if (accept) begin
      op_q   <= FUNCT3;
      dest_q <= DEST_ADDRESS;
      neg_q  <= neg_in;
      fast_q <= fast_hit;
      opnd_q <= is_mul ? mag1 : mag2;
      cnt    <= fast_hit ? 5'd0 : 5'd31;
      // Fast-path result parks in acc and is published on the following edge.
      acc    <= fast_hit ? {{WIDTH{1'b0}}, fast_val}
                         : {{WIDTH{1'b0}}, (is_mul ? mag2 : mag1)};
    end else if (FLUSH) begin
      fast_q <= 1'b0;
    end else if (fast_q) begin
      fast_q         <= 1'b0;
      RESULT         <= acc[WIDTH-1:0];
      RESULT_ADDRESS <= dest_q;
    end else if (state == CALC) begin
      acc <= acc_nxt;
      if (cnt != 5'd0)
        cnt <= cnt - 5'd1;
      else begin
        RESULT         <= final_res;
        RESULT_ADDRESS <= dest_q;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed RV32M cases, random operations against an arithmetic model,
// and handshake/flush/reset scenarios.
module tb_mul_div_unit;
  logic        CLK, RESET_N, START, FLUSH;
  logic [2:0]  FUNCT3;
  logic [31:0] OPERAND1, OPERAND2, RESULT;
  logic [4:0]  DEST_ADDRESS, RESULT_ADDRESS;
  logic        BUSY, RESULT_VALID;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  mul_div_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .FUNCT3(FUNCT3),
    .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .DEST_ADDRESS(DEST_ADDRESS),
    .FLUSH(FLUSH), .BUSY(BUSY), .RESULT_VALID(RESULT_VALID),
    .RESULT(RESULT), .RESULT_ADDRESS(RESULT_ADDRESS)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    ia = a; ib = b; sa = ia; sb = ib; ua = a; ub = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 32;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Samples #1 after each edge until RESULT_VALID, bounded at 40 edges.
  task automatic wait_valid(input bit exp_busy, input int lat0, output int lat, output bit busy_bad);
    lat = lat0;
    busy_bad = 1'b0;
    while (RESULT_VALID !== 1'b1 && lat < 40) begin
      if (BUSY !== exp_busy) busy_bad = 1'b1;
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic count_pulses(input int edges, output int n);
    n = 0;
    repeat (edges) begin
      @(posedge CLK); #1;
      if (RESULT_VALID === 1'b1) n++;
    end
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input string tag, input bit tail);
    logic [31:0] exp;
    int exp_lat, lat;
    bit busy_bad;
    exp = ref_model(f, a, b);
    exp_lat = ref_latency(f, a, b);
    @(negedge CLK);
    START = 1'b1; FUNCT3 = f; OPERAND1 = a; OPERAND2 = b; DEST_ADDRESS = rd;
    @(posedge CLK); #1;
    START = 1'b0; OPERAND1 = $urandom; OPERAND2 = $urandom;
    wait_valid(exp_lat != 1, 0, lat, busy_bad);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy"}, {31'b0, busy_bad}, 32'd0);
    chk({tag, " busy_at_done"}, {31'b0, BUSY}, 32'd0);
    chk({tag, " result"}, RESULT, exp);
    chk({tag, " rd"}, {27'b0, RESULT_ADDRESS}, {27'b0, rd});
    last_res = exp;
    last_rd = rd;
    if (tail) begin
      @(posedge CLK); #1;
      chk({tag, " pulse_width"}, {31'b0, RESULT_VALID}, 32'd0);
      chk({tag, " hold"}, RESULT, exp);
    end
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int lat, n;
    bit busy_bad;

    RESET_N = 1'b0; START = 1'b0; FLUSH = 1'b0; FUNCT3 = '0;
    OPERAND1 = '0; OPERAND2 = '0; DEST_ADDRESS = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset busy", {31'b0, BUSY}, 32'd0);
    chk("reset valid", {31'b0, RESULT_VALID}, 32'd0);
    chk("reset result", RESULT, 32'd0);
    chk("reset rd", {27'b0, RESULT_ADDRESS}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    do_op(3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  "mul",    1'b1);
    do_op(3'd1, 32'h80000000, 32'hFFFFFFFF, 5'd6,  "mulh",   1'b1);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd7,  "mulhsu", 1'b1);
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 5'd8,  "mulhu",  1'b1);
    do_op(3'd4, 32'hFFFFFFF9, 32'd2,        5'd9,  "div",    1'b1);
    do_op(3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, "rem",    1'b1);
    do_op(3'd5, 32'd100,      32'd7,        5'd11, "divu",   1'b1);
    do_op(3'd7, 32'd100,      32'd7,        5'd12, "remu",   1'b1);
    do_op(3'd5, 32'd5,        32'd0,        5'd13, "divu0",  1'b1);
    do_op(3'd6, 32'd5,        32'd0,        5'd14, "rem0",   1'b1);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, "divovf", 1'b1);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd0,  "removf", 1'b1);

    for (int i = 0; i < 24; i++) begin
      f  = 3'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      a  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      do_op(f, a, b, rd, "random", 1'b1);
    end

    // START during CALC is dropped.
    @(negedge CLK);
    START = 1'b1; FUNCT3 = 3'd5; OPERAND1 = 32'd100; OPERAND2 = 32'd7; DEST_ADDRESS = 5'd3;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    START = 1'b1; FUNCT3 = 3'd0; OPERAND1 = 32'd2; OPERAND2 = 32'd3; DEST_ADDRESS = 5'd9;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_valid(1'b1, 5, lat, busy_bad);
    chk("ignore latency", 32'(lat), 32'd32);
    chk("ignore busy", {31'b0, busy_bad}, 32'd0);
    chk("ignore result", RESULT, 32'd14);
    chk("ignore rd", {27'b0, RESULT_ADDRESS}, 32'd3);
    count_pulses(40, n);
    chk("ignore no_extra_pulse", 32'(n), 32'd0);

    // START in DONE: second op captured on the DONE edge, BUSY with no idle gap.
    do_op(3'd5, 32'd1000, 32'd3, 5'd1, "b2b first",  1'b0);
    do_op(3'd5, 32'd50,   32'd5, 5'd2, "b2b second", 1'b1);

    // FLUSH at n+10 kills the op and keeps the old result.
    @(negedge CLK);
    START = 1'b1; FUNCT3 = 3'd5; OPERAND1 = 32'd100; OPERAND2 = 32'd7; DEST_ADDRESS = 5'd4;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    chk("flush busy", {31'b0, BUSY}, 32'd0);
    chk("flush valid", {31'b0, RESULT_VALID}, 32'd0);
    count_pulses(40, n);
    chk("flush no_pulse", 32'(n), 32'd0);
    chk("flush kept result", RESULT, last_res);
    chk("flush kept rd", {27'b0, RESULT_ADDRESS}, {27'b0, last_rd});

    // Asynchronous reset mid-CALC clears outputs before the next edge.
    @(negedge CLK);
    START = 1'b1; FUNCT3 = 3'd7; OPERAND1 = 32'd12345; OPERAND2 = 32'd77; DEST_ADDRESS = 5'd21;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst busy", {31'b0, BUSY}, 32'd0);
    chk("arst valid", {31'b0, RESULT_VALID}, 32'd0);
    chk("arst result", RESULT, 32'd0);
    chk("arst rd", {27'b0, RESULT_ADDRESS}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    count_pulses(40, n);
    chk("arst no_pulse", 32'(n), 32'd0);

    // FLUSH wins over START in the same cycle.
    @(negedge CLK);
    START = 1'b1; FLUSH = 1'b1; FUNCT3 = 3'd5; OPERAND1 = 32'd9; OPERAND2 = 32'd2; DEST_ADDRESS = 5'd17;
    @(posedge CLK); #1;
    START = 1'b0; FLUSH = 1'b0;
    chk("flush_start busy", {31'b0, BUSY}, 32'd0);
    count_pulses(40, n);
    chk("flush_start no_pulse", 32'(n), 32'd0);

    do_op(3'd1, 32'hFFFFFFF0, 32'h00012345, 5'd30, "recover", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
